// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver definitions
// Contents: rx FSM state encoding and the UART data-bit count.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO
// Ports: clock, reset_n (async active-low); i_wr_en/i_wr_data write side;
//   i_rd_en pops the head when o_valid; o_rd_data head word (0 while empty);
//   o_valid non-empty; o_full; o_count occupancy.
// A write while full is accepted only if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_valid   = r_count != '0;
    assign o_full    = r_count == DEPTH_C;
    assign w_rd      = i_rd_en && o_valid;
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_rd);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver feeding a first-word-fall-through FIFO
// Ports: clock, reset_n (async active-low); uart_rx_pin serial line (idle high);
//   rx_data/rx_valid/rx_ready FIFO head handshake; rx_count occupancy;
//   overflow, framing_error sticky flags, cleared by a clear_errors pulse.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
//   majority around the sample point instead of a single sample.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int UART_CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          uart_rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overflow,
    output logic                          framing_error,
    input  logic                          clear_errors
);
    localparam int CW = $clog2(UART_CLKS_PER_BIT + 1);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(UART_CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(UART_CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    rx_state_t                 r_state;
    logic [1:0]                r_sync;
    logic [CW-1:0]             r_cnt;
    logic [BW-1:0]             r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_overflow;
    logic                      r_framing;
    logic                      w_line;
    logic                      w_bit;
    logic                      w_exp;
    logic                      w_stop_smp;
    logic                      w_push;
    logic                      w_full;
    logic                      w_ovf_evt;
    logic                      w_frm_evt;

    assign w_line = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
    // r_sync[0] is the value w_line takes next cycle, so the vote covers
    // expiry-1, expiry and expiry+1 without delaying the decision.
    logic r_prev;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_prev <= 1'b1;
        else r_prev <= w_line;
    end
    assign w_bit = (r_prev & w_line) | (r_prev & r_sync[0]) | (w_line & r_sync[0]);
`else
    assign w_bit = w_line;
`endif

    assign w_exp      = r_cnt == CNT_ONE;
    assign w_stop_smp = (r_state == RX_STOP) && w_exp;
    assign w_push     = w_stop_smp && w_bit;
    assign w_frm_evt  = w_stop_smp && !w_bit;
    assign w_ovf_evt  = w_push && w_full && !(rx_valid && rx_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b11;
        else r_sync <= {r_sync[0], uart_rx_pin};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (!w_line) begin
                        r_state <= RX_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                RX_START: begin
                    if (w_exp) begin
                        r_state   <= w_bit ? RX_IDLE : RX_DATA;
                        r_cnt     <= CNT_FULL;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (w_exp) begin
                        r_shift   <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BIT_ONE;
                        r_cnt     <= CNT_FULL;
                        if (r_bit_idx == BIT_LAST) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    // Leaving mid-stop-bit lets the next start edge be caught.
                    if (w_exp) r_state <= RX_IDLE;
                    else r_cnt <= r_cnt - CNT_ONE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    // A new error event outranks a coincident clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_framing  <= 1'b0;
        end else begin
            r_overflow <= w_ovf_evt | (r_overflow & ~clear_errors);
            r_framing  <= w_frm_evt | (r_framing & ~clear_errors);
        end
    end

    assign overflow      = r_overflow;
    assign framing_error = r_framing;

    sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_wr_en  (w_push),
        .i_wr_data(r_shift),
        .i_rd_en  (rx_ready),
        .o_rd_data(rx_data),
        .o_valid  (rx_valid),
        .o_full   (w_full),
        .o_count  (rx_count)
    );
endmodule
